mtc_ptcalc_scheduler: RTL and testbench
=======================================

# mtc_ptcalc_scheduler

Allocates the shared pT-calculation blocks to the sector-logic candidates arriving each bunch crossing, ahead of the MTC builder. It writes the process-channel index that the MTC builder later uses to select the matching pT-calc result. It also flags a candidate busy when no pT-calc block is free. Each block's occupancy is tracked until that block reports done or a timeout expires.

## Interface
Parameters:
- N_SLC, 3, candidates presented per cycle, in priority order (index 0 highest).
- N_PTCALC, 3, number of shared pT-calc blocks.
- CH_W, 2, width of the process-channel field; must satisfy 2**CH_W >= N_PTCALC.
- IDX_W, 2, width of the candidate index; must satisfy 2**IDX_W >= N_SLC.
- PTCALC_TIMEOUT, 64, maximum number of cycles a block stays occupied without `ptcalc_done_i`.
- CNT_W, 16, width of the busy-drop counter.

Ports:
- clock  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- slc_valid_i  in  N_SLC  per-candidate valid, sampled every cycle.
- ptcalc_done_i  in  N_PTCALC  one-cycle pulse from block k when it finishes its result.
- slc_out_valid_o  out  N_SLC  registered copy of `slc_valid_i`.
- slc_process_ch_o  out  N_SLC*CH_W  packed channel per candidate; field i occupies bits [i*CH_W +: CH_W].
- slc_busy_o  out  N_SLC  candidate was valid but no block was free.
- ptcalc_start_o  out  N_PTCALC  one-cycle start pulse to block k.
- ptcalc_src_o  out  N_PTCALC*IDX_W  candidate index loaded into block k; valid only while `ptcalc_start_o[k]` is high.
- ptcalc_inuse_o  out  N_PTCALC  occupancy state of each block.
- timeout_o  out  N_PTCALC  one-cycle pulse when block k is force-released by timeout.
- busy_cnt_o  out  CNT_W  count of busy candidates; saturates at all-ones.

## Operation
State:
- `inuse[N_PTCALC]`: block occupancy.
- `tmr[k]`: per-block counter, width clog2(PTCALC_TIMEOUT+1).
- `rr_ptr`: round-robin pointer, range 0..N_PTCALC-1.
- `busy_cnt`: busy-drop counter.

Allocation, evaluated each cycle on the registered `inuse` (free set F = ~inuse):
- Walk candidates from i=0 to N_SLC-1.
- For each valid candidate, grant the first free block in F, searching from `rr_ptr` upward with wrap at N_PTCALC.
- Remove each granted block from F before evaluating the next candidate.
- A valid candidate that finds F empty is busy.
- An invalid candidate receives no grant, ch=0 and busy=0.
- If any grant is made, `rr_ptr` becomes (last granted block + 1) mod N_PTCALC. Otherwise `rr_ptr` is unchanged.

Per-block update for block k:
- On grant: `inuse[k]` <= 1, `tmr[k]` <= 0.
- While `inuse[k]` is set and no done arrives: `tmr[k]` increments.
- `ptcalc_done_i[k]` with `inuse[k]`=1: `inuse[k]` <= 0.
- `ptcalc_done_i[k]` with `inuse[k]`=0: ignored.
- `tmr[k]` reaches PTCALC_TIMEOUT-1 with no done: `inuse[k]` <= 0 and `timeout_o[k]` pulses.

Counter rule: `busy_cnt` increments by popcount(`slc_busy`) each cycle and saturates at 2**CNT_W-1; it never wraps.

Reset (`rst`=1): all outputs, `inuse`, `tmr`, `rr_ptr` and `busy_cnt` are set to 0. `rst` takes priority over all other inputs in the same cycle.

## Timing
- Latency is 1 cycle. Inputs sampled at edge t appear at edge t+1 on `slc_out_valid_o`, `slc_process_ch_o`, `slc_busy_o`, `ptcalc_start_o` and `ptcalc_src_o`.
- `ptcalc_inuse_o[k]` rises in the same cycle that `ptcalc_start_o[k]` is high.
- A done pulse in cycle t frees the block from cycle t+1. A candidate arriving in cycle t cannot use that block and is marked busy if no other block is free.
- Done and timeout on the same block in the same cycle: done wins and `timeout_o` does not pulse.
- Timeout: with no done, `timeout_o[k]` pulses exactly PTCALC_TIMEOUT cycles after `ptcalc_start_o[k]`, and `inuse[k]` clears together with that pulse.
- `rst` asserted mid-operation drops all occupancy with no timeout pulses. Done pulses that arrive after reset hits idle blocks and are ignored.
- Full throughput: up to N_PTCALC grants per cycle, with no bubbles.

## Test plan
- Reset, then `slc_valid_i`=3'b111 in one cycle. Next cycle: ch = {0,1,2} for slc0..2, `ptcalc_start_o`=3'b111, `ptcalc_src_o` = {0,1,2}, busy=0, `rr_ptr`=0.
- All blocks in use, `slc_valid_i`=3'b101. Next cycle: `slc_busy_o`=3'b101, `ptcalc_start_o`=0, `busy_cnt_o`=2.
- `ptcalc_done_i`=3'b010 and slc0 valid in cycle t. At t+1, slc0 is busy. slc0 valid again at t+1 gives ch=1 at t+2.
- Single candidate per cycle, with done pulsed the cycle after each start. Channels granted rotate 0,1,2,0.
- PTCALC_TIMEOUT=8, start with no done. `timeout_o[k]` pulses 8 cycles after start and `inuse` clears. A done pulse with no outstanding work on that block has no effect.
- Assert `rst` while 2 blocks are in use. Next cycle: all outputs 0, `busy_cnt_o`=0. A candidate arriving after reset gets ch=0.

Source files
------------

// File: rtl/mtc_ptcalc_scheduler.sv
// mtc_ptcalc_scheduler: assigns shared pT-calc blocks to sector-logic candidates
// each bunch crossing. It tracks block occupancy until done or timeout, and counts
// candidates dropped because every block was busy.
module mtc_ptcalc_scheduler #(
    parameter int unsigned N_SLC          = 3,
    parameter int unsigned N_PTCALC       = 3,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned PTCALC_TIMEOUT = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [N_SLC-1:0]          slc_valid_i,
    input  logic [N_PTCALC-1:0]       ptcalc_done_i,
    output logic [N_SLC-1:0]          slc_out_valid_o,
    output logic [N_SLC*CH_W-1:0]     slc_process_ch_o,
    output logic [N_SLC-1:0]          slc_busy_o,
    output logic [N_PTCALC-1:0]       ptcalc_start_o,
    output logic [N_PTCALC*IDX_W-1:0] ptcalc_src_o,
    output logic [N_PTCALC-1:0]       ptcalc_inuse_o,
    output logic [N_PTCALC-1:0]       timeout_o,
    output logic [CNT_W-1:0]          busy_cnt_o
);

    localparam int unsigned TMR_W = $clog2(PTCALC_TIMEOUT + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    // Sequential state
    logic [N_PTCALC-1:0] r_inuse;
    logic [TMR_W-1:0]    r_tmr [N_PTCALC];
    logic [CH_W-1:0]     r_rr_ptr;

    // Allocation results
    logic [N_PTCALC-1:0]       w_free;
    logic [N_PTCALC-1:0]       w_grant;
    logic [N_SLC*CH_W-1:0]     w_ch;
    logic [N_SLC-1:0]          w_busy;
    logic [N_PTCALC*IDX_W-1:0] w_src;
    logic                      w_any;
    logic                      w_found;
    logic [CH_W-1:0]           w_k;
    logic [CH_W-1:0]           w_last;
    logic [CH_W-1:0]           w_rr_nxt;
    logic [SUM_W-1:0]          w_sum;
    logic [CNT_W-1:0]          w_cnt_nxt;

    assign ptcalc_inuse_o = r_inuse;

    // Block index reached by stepping 'off' places up from 'base', wrapping at N_PTCALC
    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_PTCALC) s = s - N_PTCALC;
        return CH_W'(s);
    endfunction

    // Priority walk over candidates, round-robin search over the free blocks
    always_comb begin : alloc
        w_free  = ~r_inuse;
        w_grant = '0;
        w_ch    = '0;
        w_busy  = '0;
        w_src   = '0;
        w_any   = 1'b0;
        w_found = 1'b0;
        w_k     = '0;
        w_last  = '0;
        for (int unsigned i = 0; i < N_SLC; i++) begin
            w_found = 1'b0;
            if (slc_valid_i[i]) begin
                for (int unsigned j = 0; j < N_PTCALC; j++) begin
                    w_k = wrap_idx(r_rr_ptr, j);
                    if (!w_found && w_free[w_k]) begin
                        w_found                        = 1'b1;
                        w_free[w_k]                    = 1'b0;
                        w_grant[w_k]                   = 1'b1;
                        w_ch[i*CH_W +: CH_W]           = w_k;
                        w_src[32'(w_k)*IDX_W +: IDX_W] = IDX_W'(i);
                        w_last                         = w_k;
                        w_any                          = 1'b1;
                    end
                end
                if (!w_found) w_busy[i] = 1'b1;
            end
        end
    end

    // Pointer moves past the last block granted this cycle
    always_comb begin : rr_next
        w_rr_nxt = r_rr_ptr;
        if (w_any) begin
            if (w_last == CH_W'(N_PTCALC - 1)) w_rr_nxt = '0;
            else                               w_rr_nxt = w_last + CH_W'(1);
        end
    end

    // Saturating accumulation of busy candidates
    always_comb begin : busy_sum
        w_sum = {1'b0, busy_cnt_o};
        for (int unsigned i = 0; i < N_SLC; i++) begin
            w_sum = w_sum + SUM_W'(w_busy[i]);
        end
        w_cnt_nxt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    // Registered candidate-side and start outputs, pointer and counter
    always_ff @(posedge clock) begin
        if (rst) begin
            slc_out_valid_o  <= '0;
            slc_process_ch_o <= '0;
            slc_busy_o       <= '0;
            ptcalc_start_o   <= '0;
            ptcalc_src_o     <= '0;
            busy_cnt_o       <= '0;
            r_rr_ptr         <= '0;
        end else begin
            slc_out_valid_o  <= slc_valid_i;
            slc_process_ch_o <= w_ch;
            slc_busy_o       <= w_busy;
            ptcalc_start_o   <= w_grant;
            ptcalc_src_o     <= w_src;
            busy_cnt_o       <= w_cnt_nxt;
            r_rr_ptr         <= w_rr_nxt;
        end
    end

    // Per-block occupancy: set on grant, cleared by done (preferred) or by timeout
    always_ff @(posedge clock) begin
        if (rst) begin
            r_inuse   <= '0;
            timeout_o <= '0;
            for (int unsigned k = 0; k < N_PTCALC; k++) r_tmr[k] <= '0;
        end else begin
            timeout_o <= '0;
            for (int unsigned k = 0; k < N_PTCALC; k++) begin
                if (w_grant[k]) begin
                    r_inuse[k] <= 1'b1;
                    r_tmr[k]   <= '0;
                end else if (r_inuse[k]) begin
                    if (ptcalc_done_i[k]) begin
                        r_inuse[k] <= 1'b0;
                        r_tmr[k]   <= '0;
                    end else if (r_tmr[k] == TMR_W'(PTCALC_TIMEOUT - 1)) begin
                        r_inuse[k]   <= 1'b0;
                        r_tmr[k]     <= '0;
                        timeout_o[k] <= 1'b1;
                    end else begin
                        r_tmr[k] <= r_tmr[k] + TMR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mtc_ptcalc_scheduler.sv
// Testbench for mtc_ptcalc_scheduler: a reference model predicts each cycle's
// outputs into a queue, and a monitor compares them against the DUT.
module tb_mtc_ptcalc_scheduler;

    localparam int N  = 3;
    localparam int T  = 8;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   slc_valid_i = '0;
    logic [2:0]   ptcalc_done_i = '0;
    logic [2:0]   slc_out_valid_o;
    logic [5:0]   slc_process_ch_o;
    logic [2:0]   slc_busy_o;
    logic [2:0]   ptcalc_start_o;
    logic [5:0]   ptcalc_src_o;
    logic [2:0]   ptcalc_inuse_o;
    logic [2:0]   timeout_o;
    logic [CW-1:0] busy_cnt_o;

    mtc_ptcalc_scheduler #(
        .N_SLC(3), .N_PTCALC(3), .CH_W(2), .IDX_W(2),
        .PTCALC_TIMEOUT(T), .CNT_W(CW)
    ) dut (
        .clock(clock), .rst(rst),
        .slc_valid_i(slc_valid_i), .ptcalc_done_i(ptcalc_done_i),
        .slc_out_valid_o(slc_out_valid_o), .slc_process_ch_o(slc_process_ch_o),
        .slc_busy_o(slc_busy_o), .ptcalc_start_o(ptcalc_start_o),
        .ptcalc_src_o(ptcalc_src_o), .ptcalc_inuse_o(ptcalc_inuse_o),
        .timeout_o(timeout_o), .busy_cnt_o(busy_cnt_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]    valid;
        logic [5:0]    ch;
        logic [2:0]    busy;
        logic [2:0]    start;
        logic [5:0]    src;
        logic [2:0]    inuse;
        logic [2:0]    tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: occupancy, cycle each block was started, pointer, counter
    bit   m_inuse[N];
    int   m_start[N];
    int   m_rr  = 0;
    int   m_cnt = 0;
    int   m_cyc = 0;
    int   m_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and predict what the DUT shows after the next edge
    task automatic step(input logic r, input logic [2:0] v, input logic [2:0] d);
        exp_t e;
        bit   fr[N];
        int   g;
        int   last;
        int   pop;
        @(negedge clock);
        rst = r;
        slc_valid_i = v;
        ptcalc_done_i = d;
        m_cyc++;
        e = '0;
        if (r) begin
            for (int k = 0; k < N; k++) m_inuse[k] = 0;
            m_rr = 0;
            m_cnt = 0;
            q.push_back(e);
            return;
        end
        e.valid = v;
        for (int k = 0; k < N; k++) fr[k] = !m_inuse[k];
        last = -1;
        pop = 0;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                g = -1;
                for (int j = 0; j < N; j++) begin
                    int k;
                    k = (m_rr + j) % N;
                    if (g < 0 && fr[k]) g = k;
                end
                if (g < 0) begin
                    e.busy[i] = 1'b1;
                    pop++;
                end else begin
                    fr[g] = 0;
                    e.start[g] = 1'b1;
                    e.ch[i*2 +: 2] = g[1:0];
                    e.src[g*2 +: 2] = i[1:0];
                    last = g;
                end
            end
        end
        if (last >= 0) begin
            m_rr = (last + 1) % N;
            m_last = last;
        end
        for (int k = 0; k < N; k++) begin
            if (e.start[k]) begin
                m_inuse[k] = 1;
                m_start[k] = m_cyc;
            end else if (m_inuse[k]) begin
                if (d[k]) m_inuse[k] = 0;
                else if (m_cyc - m_start[k] == T) begin
                    m_inuse[k] = 0;
                    e.tmo[k] = 1'b1;
                end
            end
            e.inuse[k] = m_inuse[k];
        end
        m_cnt = (m_cnt + pop > CMAX) ? CMAX : m_cnt + pop;
        e.cnt = CW'(m_cnt);
        q.push_back(e);
    endtask

    function automatic logic [2:0] idle_mask();
        logic [2:0] m;
        for (int k = 0; k < N; k++) m[k] = !m_inuse[k];
        return m;
    endfunction

    // Monitor: compare every predicted cycle against the DUT, away from the edge
    initial begin
        exp_t e;
        logic [5:0] mask;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < N; k++) mask[k*2 +: 2] = {2{e.start[k]}};
                chk("out_valid", 32'(slc_out_valid_o), 32'(e.valid));
                chk("process_ch", 32'(slc_process_ch_o), 32'(e.ch));
                chk("busy", 32'(slc_busy_o), 32'(e.busy));
                chk("start", 32'(ptcalc_start_o), 32'(e.start));
                chk("src", 32'(ptcalc_src_o & mask), 32'(e.src));
                chk("inuse", 32'(ptcalc_inuse_o), 32'(e.inuse));
                chk("timeout", 32'(timeout_o), 32'(e.tmo));
                chk("busy_cnt", 32'(busy_cnt_o), 32'(e.cnt));
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic       r;
        logic [2:0] v;
        logic [2:0] d;

        step(1'b1, 3'b000, 3'b000);
        step(1'b1, 3'b000, 3'b000);

        // All three candidates granted, then everything busy
        step(1'b0, 3'b111, 3'b000);
        step(1'b0, 3'b101, 3'b000);
        // Done frees block 1 only from the following cycle
        step(1'b0, 3'b001, 3'b010);
        step(1'b0, 3'b001, 3'b000);
        step(1'b0, 3'b000, 3'b111);

        // One candidate per cycle, released right after start: channels rotate
        repeat (4) begin
            step(1'b0, 3'b001, 3'b000);
            step(1'b0, 3'b000, 3'(1 << m_last));
        end

        // Timeout with a stray done pulse to idle blocks
        step(1'b0, 3'b001, 3'b000);
        for (int c = 0; c < 10; c++) step(1'b0, 3'b000, (c == 3) ? idle_mask() : 3'b000);

        // Reset with two blocks busy, then a fresh grant
        step(1'b0, 3'b011, 3'b000);
        step(1'b0, 3'b000, 3'b000);
        step(1'b1, 3'b000, 3'b000);
        step(1'b0, 3'b000, 3'b111);
        step(1'b0, 3'b001, 3'b000);

        // Sustained overload: counter saturates, blocks recycle via timeout
        for (int c = 0; c < 20; c++) step(1'b0, 3'b111, 3'b000);
        step(1'b1, 3'b000, 3'b000);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 80) == 0);
            v = 3'($urandom);
            for (int k = 0; k < N; k++) d[k] = ($urandom_range(0, 5) == 0);
            step(r, v, d);
        end

        step(1'b0, 3'b000, 3'b000);
        @(posedge clock);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
